// File: rtl/temp_zone_classifier.sv
// Registered temperature-zone classifier with downward hysteresis,
// persistence filtering and a sticky, software-acknowledged danger alarm.
module temp_zone_classifier #(
   parameter int unsigned W       = 5,
   parameter int unsigned T_LOW   = 6,
   parameter int unsigned T_NORM  = 9,
   parameter int unsigned T_HIGH  = 11,
   parameter int unsigned HYST    = 1,
   parameter int unsigned PERSIST = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] a,
   input  logic         a_valid,
   input  logic         alarm_ack,
   output logic [3:0]   y,
   output logic         zone_chg,
   output logic         alarm,
   output logic [W-1:0] temp_q
);

   localparam int CW = $clog2(PERSIST + 1);

   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(PERSIST);

   localparam logic [W-1:0] B0   = W'(T_LOW);
   localparam logic [W-1:0] B1   = W'(T_NORM);
   localparam logic [W-1:0] B2   = W'(T_HIGH);
   localparam logic [W-1:0] B0_H = W'(T_LOW - HYST);
   localparam logic [W-1:0] B1_H = W'(T_NORM - HYST);
   localparam logic [W-1:0] B2_H = W'(T_HIGH - HYST);

   localparam logic [1:0] Z_DANGER = 2'd3;

   logic [1:0]    zone_q, zone_d;
   logic [1:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          zone_chg_q, zone_chg_d;
   logic          alarm_q, alarm_d;
   logic [W-1:0]  temp_q_q, temp_q_d;

   logic [2:0]    above;
   logic [1:0]    c;

   // Boundaries already crossed by the committed zone are lowered by HYST.
   always_comb begin
      above[0] = (zone_q > 2'd0) ? (a > B0_H) : (a > B0);
      above[1] = (zone_q > 2'd1) ? (a > B1_H) : (a > B1);
      above[2] = (zone_q > 2'd2) ? (a > B2_H) : (a > B2);
      c = 2'(above[0]) + 2'(above[1]) + 2'(above[2]);
   end

   always_comb begin
      zone_d     = zone_q;
      cand_d     = cand_q;
      cnt_d      = cnt_q;
      zone_chg_d = 1'b0;
      alarm_d    = alarm_q;
      temp_q_d   = temp_q_q;
      cnt_inc    = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
      if (a_valid) begin
         temp_q_d = a;
         if (c == zone_q) begin
            cnt_d = '0;
         end else if ((c != cand_q) || (cnt_q == '0)) begin
            cand_d = c;
            cnt_d  = CNT_ONE;
         end else begin
            cnt_d = cnt_inc;
         end
         if ((c != zone_q) && (cnt_d == CNT_MAX)) begin
            zone_d     = c;
            cnt_d      = '0;
            zone_chg_d = 1'b1;
         end
      end
      // A fresh danger commit beats a simultaneous acknowledge.
      if (zone_chg_d && (c == Z_DANGER)) begin
         alarm_d = 1'b1;
      end else if (alarm_ack && (zone_q != Z_DANGER)) begin
         alarm_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zone_q     <= 2'd0;
         cand_q     <= 2'd0;
         cnt_q      <= '0;
         zone_chg_q <= 1'b0;
         alarm_q    <= 1'b0;
         temp_q_q   <= '0;
      end else begin
         zone_q     <= zone_d;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         zone_chg_q <= zone_chg_d;
         alarm_q    <= alarm_d;
         temp_q_q   <= temp_q_d;
      end
   end

   always_comb begin
      y = 4'b1000;
      unique case (zone_q)
         2'd0: y = 4'b1000;
         2'd1: y = 4'b0100;
         2'd2: y = 4'b0010;
         2'd3: y = 4'b0001;
         default: y = 4'b1000;
      endcase
   end

   assign zone_chg = zone_chg_q;
   assign alarm    = alarm_q;
   assign temp_q   = temp_q_q;

endmodule

// File: tb/tb_temp_zone_classifier.sv
// Bench for temp_zone_classifier: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_temp_zone_classifier;

   localparam int W = 5;
   localparam int T_LOW = 6;
   localparam int T_NORM = 9;
   localparam int T_HIGH = 11;
   localparam int HYST = 1;
   localparam int P = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] a = '0;
   logic         a_valid = 1'b0;
   logic         alarm_ack = 1'b0;
   logic [3:0]   y;
   logic         zone_chg;
   logic         alarm;
   logic [W-1:0] temp_q;

   int checks = 0;
   int errors = 0;
   int chg_seen = 0;

   temp_zone_classifier #(
      .W(W), .T_LOW(T_LOW), .T_NORM(T_NORM), .T_HIGH(T_HIGH),
      .HYST(HYST), .PERSIST(P)
   ) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .a_valid(a_valid),
      .alarm_ack(alarm_ack), .y(y), .zone_chg(zone_chg),
      .alarm(alarm), .temp_q(temp_q)
   );

   always #5 clk = ~clk;

   // Behavioural model: zone = number of thresholds exceeded, where
   // thresholds already passed by the committed zone sit HYST lower.
   function automatic int cand_of(input int av, input int zn);
      int bnd[3];
      int n;
      bnd[0] = T_LOW;
      bnd[1] = T_NORM;
      bnd[2] = T_HIGH;
      n = 0;
      for (int i = 0; i < 3; i++) begin
         if (av > bnd[i] - ((zn > i) ? HYST : 0)) n++;
      end
      return n;
   endfunction

   int           m_zone, m_runc, m_runlen;
   logic         m_chg, m_alarm;
   logic [W-1:0] m_temp;

   always @(posedge clk or negedge rst_n) begin : model
      int c, rl, rc;
      bit com;
      if (!rst_n) begin
         m_zone   <= 0;
         m_runc   <= 0;
         m_runlen <= 0;
         m_chg    <= 1'b0;
         m_alarm  <= 1'b0;
         m_temp   <= '0;
      end else begin
         rl  = m_runlen;
         rc  = m_runc;
         com = 1'b0;
         c   = m_zone;
         if (a_valid) begin
            c = cand_of(int'(a), m_zone);
            if (c == m_zone) begin
               rl = 0;
            end else begin
               if (rl > 0 && c == rc) rl++;
               else begin
                  rc = c;
                  rl = 1;
               end
               if (rl >= P) begin
                  com = 1'b1;
                  rl  = 0;
               end
            end
            m_temp <= a;
         end
         m_runlen <= rl;
         m_runc   <= rc;
         m_chg    <= com;
         if (com) m_zone <= c;
         if (com && c == 3) m_alarm <= 1'b1;
         else if (alarm_ack && m_zone != 3) m_alarm <= 1'b0;
      end
   end

   always @(negedge clk) begin : compare
      logic [3:0] ey;
      ey = 4'b1000 >> m_zone;
      checks++;
      if (y !== ey || zone_chg !== m_chg || alarm !== m_alarm ||
          temp_q !== m_temp) begin
         errors++;
         $display("FAIL model t=%0t y=%b/%b chg=%b/%b alarm=%b/%b temp=%0d/%0d",
                  $time, y, ey, zone_chg, m_chg, alarm, m_alarm,
                  temp_q, m_temp);
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
      end
   endtask

   task automatic cyc(input bit v, input int val, input bit ack);
      a_valid   = v;
      a         = W'(val);
      alarm_ack = ack;
      @(posedge clk);
      #1;
      if (zone_chg) chg_seen++;
      a_valid   = 1'b0;
      alarm_ack = 1'b0;
   endtask

   task automatic send(input int val, input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, val, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a       = W'($urandom_range(0, 31));
         a_valid = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      chk("reset_y", int'(y), 8);
      chk("reset_alarm", int'(alarm), 0);
      chk("reset_chg", int'(zone_chg), 0);
      chk("reset_temp", int'(temp_q), 0);
      rst_n = 1'b1;
      cyc(1'b0, 0, 1'b0);

      chg_seen = 0;
      send(7, 2);
      chk("norm_early_y", int'(y), 8);
      send(7, 1);
      chk("norm_y", int'(y), 4);
      chk("norm_chg", int'(zone_chg), 1);
      cyc(1'b0, 0, 1'b0);
      chk("norm_pulses", chg_seen, 1);
      chk("norm_temp", int'(temp_q), 7);

      chg_seen = 0;
      send(6, 3);
      chk("hyst_hold_y", int'(y), 4);
      chk("hyst_hold_pulses", chg_seen, 0);
      send(5, 3);
      chk("hyst_drop_y", int'(y), 8);

      send(7, 2);
      send(5, 1);
      send(7, 2);
      chk("broken_y5", int'(y), 8);
      send(7, 1);
      chk("broken_y6", int'(y), 4);

      send(5, 3);
      chk("gap_base_y", int'(y), 8);
      cyc(1'b1, 7, 1'b0);
      cyc(1'b0, 3, 1'b0);
      cyc(1'b1, 7, 1'b0);
      cyc(1'b0, 31, 1'b0);
      cyc(1'b1, 5, 1'b0);
      cyc(1'b1, 7, 1'b0);
      cyc(1'b0, 0, 1'b0);
      cyc(1'b1, 7, 1'b0);
      cyc(1'b0, 0, 1'b0);
      chk("gap_y5", int'(y), 8);
      cyc(1'b1, 7, 1'b0);
      chk("gap_y6", int'(y), 4);

      send(5, 3);
      send(12, 3);
      chk("danger_y", int'(y), 1);
      chk("danger_alarm", int'(alarm), 1);
      cyc(1'b0, 0, 1'b1);
      chk("ack_ignored", int'(alarm), 1);
      send(10, 3);
      chk("alta_y", int'(y), 2);
      chk("alta_alarm", int'(alarm), 1);
      cyc(1'b0, 0, 1'b1);
      chk("ack_clear", int'(alarm), 0);

      send(7, 3);
      chk("jump_base_y", int'(y), 4);
      chg_seen = 0;
      send(31, 2);
      chk("jump_mid_y", int'(y), 4);
      send(31, 1);
      chk("jump_y", int'(y), 1);
      cyc(1'b0, 0, 1'b0);
      chk("jump_pulses", chg_seen, 1);

      rst_n = 1'b0;
      cyc(1'b0, 0, 1'b0);
      rst_n = 1'b1;
      send(12, 2);
      rst_n = 1'b0;
      cyc(1'b0, 0, 1'b0);
      rst_n = 1'b1;
      send(12, 1);
      chk("midrst_y", int'(y), 8);
      send(12, 2);
      chk("midrst_y3", int'(y), 1);
      chk("midrst_alarm", int'(alarm), 1);

      for (int i = 0; i < 3000; i++) begin
         int v;
         if ($urandom_range(0, 199) == 0) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
         end
         v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                         : int'($urandom_range(3, 14));
         cyc(1'($urandom_range(0, 9) < 7), v,
             1'($urandom_range(0, 9) == 0));
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
